// File: rtl/id_imm_stage_ctrl_pkg.sv
// Shared constants for the ID-stage immediate controller: one-hot EXTOp codes,
// RV32 opcode values and skid-buffer state codes.
package id_imm_stage_ctrl_pkg;

  localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/id_imm_stage_ctrl_decode.sv
// imm_op_decode: opcode/funct3 -> one-hot EXTOp + imm_used, and raw field slicing.
// EXT: immediate extension unit driven by those fields.
module imm_op_decode
  import id_imm_stage_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output logic [5:0]      ext_op,
  output logic            imm_used,
  output logic [11:0]     iimm,
  output logic [4:0]      shamt,
  output logic [11:0]     simm,
  output logic [11:0]     bimm,
  output logic [19:0]     uimm,
  output logic [19:0]     jimm
);

  logic [2:0] f3;

  assign f3    = instr[14:12];
  assign iimm  = instr[31:20];
  assign shamt = instr[24:20];
  assign simm  = {instr[31:25], instr[11:7]};
  assign bimm  = {instr[31], instr[7], instr[30:25], instr[11:8]};
  assign uimm  = instr[31:12];
  assign jimm  = {instr[31], instr[19:12], instr[20], instr[30:21]};

  always_comb begin
    ext_op   = '0;
    imm_used = 1'b0;
    unique case (instr[6:0])
      OP_IMM: begin
        // bit 30 (srai vs srli) is not part of the shift amount
        ext_op   = (f3 == F3_SLL || f3 == F3_SRX) ? EXT_CTRL_ITYPE_SHAMT : EXT_CTRL_ITYPE;
        imm_used = 1'b1;
      end
      OP_LOAD, OP_JALR: begin
        ext_op   = EXT_CTRL_ITYPE;
        imm_used = 1'b1;
      end
      OP_STORE: begin
        ext_op   = EXT_CTRL_STYPE;
        imm_used = 1'b1;
      end
      OP_BRANCH: begin
        ext_op   = EXT_CTRL_BTYPE;
        imm_used = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        ext_op   = EXT_CTRL_UTYPE;
        imm_used = 1'b1;
      end
      OP_JAL: begin
        ext_op   = EXT_CTRL_JTYPE;
        imm_used = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

module EXT
  import id_imm_stage_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [11:0]     iimm,
  input  logic [4:0]      shamt,
  input  logic [11:0]     simm,
  input  logic [11:0]     bimm,
  input  logic [19:0]     uimm,
  input  logic [19:0]     jimm,
  input  logic [5:0]      ext_op,
  output logic [XLEN-1:0] immout
);

  // branch/jump fields are halfword offsets: append the implicit zero LSB
  always_comb begin
    immout = '0;
    unique case (ext_op)
      EXT_CTRL_ITYPE_SHAMT: immout = XLEN'(shamt);
      EXT_CTRL_ITYPE:       immout = XLEN'($signed(iimm));
      EXT_CTRL_STYPE:       immout = XLEN'($signed(simm));
      EXT_CTRL_BTYPE:       immout = XLEN'($signed({bimm, 1'b0}));
      EXT_CTRL_UTYPE:       immout = XLEN'($signed({uimm, 12'h000}));
      EXT_CTRL_JTYPE:       immout = XLEN'($signed({jimm, 1'b0}));
      default:              immout = '0;
    endcase
  end

endmodule

// File: rtl/id_imm_stage_ctrl.sv
// ID-stage immediate decode + 2-entry ID/EX skid buffer with stall/flush.
// Optional perf counters enabled by defining IMM_PERF_CNT_EN.
module id_imm_stage_ctrl
  import id_imm_stage_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int EXTOP_W = 6,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    instrD,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    imm_E,
  output logic [EXTOP_W-1:0] ext_op_E,
  output logic               imm_used_E
`ifdef IMM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cnt_imm_o,
  output logic [CNT_W-1:0]   cnt_stl_o
`endif
);

  logic [5:0]      dec_op;
  logic            dec_used;
  logic [11:0]     iimm, simm, bimm;
  logic [4:0]      shamt;
  logic [19:0]     uimm, jimm;
  logic [XLEN-1:0] immout;

  imm_op_decode #(.XLEN(XLEN)) u_dec (
    .instr    (instrD),
    .ext_op   (dec_op),
    .imm_used (dec_used),
    .iimm     (iimm),
    .shamt    (shamt),
    .simm     (simm),
    .bimm     (bimm),
    .uimm     (uimm),
    .jimm     (jimm)
  );

  EXT #(.XLEN(XLEN)) u_ext (
    .iimm   (iimm),
    .shamt  (shamt),
    .simm   (simm),
    .bimm   (bimm),
    .uimm   (uimm),
    .jimm   (jimm),
    .ext_op (dec_op),
    .immout (immout)
  );

  skid_state_e        state;
  logic [XLEN-1:0]    skid_imm;
  logic [EXTOP_W-1:0] skid_op;
  logic               skid_used;
  logic               in_fire, out_fire;

  assign in_ready  = !rst && (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // MAIN entry is the output register itself; SKID catches the one extra beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      imm_E      <= '0;
      ext_op_E   <= '0;
      imm_used_E <= 1'b0;
      skid_imm   <= '0;
      skid_op    <= '0;
      skid_used  <= 1'b0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            imm_E      <= immout;
            ext_op_E   <= EXTOP_W'(dec_op);
            imm_used_E <= dec_used;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            imm_E      <= immout;
            ext_op_E   <= EXTOP_W'(dec_op);
            imm_used_E <= dec_used;
          end else if (in_fire) begin
            skid_imm  <= immout;
            skid_op   <= EXTOP_W'(dec_op);
            skid_used <= dec_used;
            state     <= ST_TWO;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            imm_E      <= skid_imm;
            ext_op_E   <= skid_op;
            imm_used_E <= skid_used;
            state      <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

`ifdef IMM_PERF_CNT_EN
  // flush does not clear the counters; a delivery in a flush cycle still counts
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_imm_o <= '0;
      cnt_stl_o <= '0;
    end else begin
      if (out_fire && imm_used_E && !(&cnt_imm_o))
        cnt_imm_o <= cnt_imm_o + 1'b1;
      if (out_valid && !out_ready && !(&cnt_stl_o))
        cnt_stl_o <= cnt_stl_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_imm_stage_ctrl.sv
// Bench for id_imm_stage_ctrl: queue-based reference model, per-cycle compare,
// directed literal cases, then randomized traffic with stall/flush/reset.
module tb_id_imm_stage_ctrl;

  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic        in_ready, out_valid, imm_used_E;
  logic [31:0] instrD, imm_E;
  logic [5:0]  ext_op_E;
`ifdef IMM_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_imm, cnt_stl;
`endif

  always #5 clk = ~clk;

  id_imm_stage_ctrl #(.XLEN(32), .EXTOP_W(6), .CNT_W(CNT_W)) dut (
`ifdef IMM_PERF_CNT_EN
    .cnt_imm_o  (cnt_imm),
    .cnt_stl_o  (cnt_stl),
`endif
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instrD     (instrD),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .imm_E      (imm_E),
    .ext_op_E   (ext_op_E),
    .imm_used_E (imm_used_E)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit on      = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] imm;
    logic [5:0]  op;
    logic        used;
  } ent_t;

  ent_t   m_q[$];
  longint m_cimm = 0, m_cstl = 0;
  bit     zeros_valid = 0;
  longint cmax = (longint'(1) << CNT_W) - 1;

  function automatic ent_t ref_dec(input logic [31:0] i);
    ent_t e;
    int   v;
    logic [2:0] f3;
    f3 = i[14:12];
    e.imm = 0; e.op = 6'b000000; e.used = 1'b0;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        if (i[6:0] == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) begin
          e.op = 6'b100000; e.imm = 32'(int'(i[24:20]));
        end else begin
          v = int'(i[31:20]); if (v >= 2048) v -= 4096;
          e.op = 6'b010000; e.imm = 32'(v);
        end
        e.used = 1'b1;
      end
      7'b0100011: begin
        v = int'(i[31:25]) * 32 + int'(i[11:7]); if (v >= 2048) v -= 4096;
        e.op = 6'b001000; e.imm = 32'(v); e.used = 1'b1;
      end
      7'b1100011: begin
        v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
        e.op = 6'b000100; e.imm = 32'(v); e.used = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        e.op = 6'b000010; e.imm = i & 32'hFFFF_F000; e.used = 1'b1;
      end
      7'b1101111: begin
        v = int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
        e.op = 6'b000001; e.imm = 32'(v); e.used = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    bit ofire, ifire;
    ofire = (m_q.size() > 0) && out_ready;
    ifire = in_valid && !rst && (m_q.size() < 2);
    if (rst) begin
      m_q.delete();
      m_cimm = 0; m_cstl = 0;
      zeros_valid = 1;
    end else begin
      if (m_q.size() > 0 && !out_ready && m_cstl < cmax) m_cstl++;
      if (ofire && m_q[0].used && m_cimm < cmax) m_cimm++;
      if (flush) m_q.delete();
      else begin
        if (ofire) void'(m_q.pop_front());
        if (ifire) begin
          m_q.push_back(ref_dec(instrD));
          zeros_valid = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (on) begin
      chk("in_ready", 64'(in_ready), 64'(!rst && m_q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("imm_E", 64'(imm_E), 64'(m_q[0].imm));
        chk("ext_op_E", 64'(ext_op_E), 64'(m_q[0].op));
        chk("imm_used_E", 64'(imm_used_E), 64'(m_q[0].used));
      end else if (zeros_valid) begin
        chk("rst_imm_E", 64'(imm_E), 64'd0);
        chk("rst_ext_op_E", 64'(ext_op_E), 64'd0);
        chk("rst_imm_used_E", 64'(imm_used_E), 64'd0);
      end
`ifdef IMM_PERF_CNT_EN
      chk("cnt_imm", 64'(cnt_imm), 64'(m_cimm));
      chk("cnt_stl", 64'(cnt_stl), 64'(m_cstl));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] ex_imm,
                      input logic [5:0] ex_op, input logic ex_used, input string nm);
    in_valid = 1'b1; instrD = ins; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_imm"}, 64'(imm_E), 64'(ex_imm));
    chk({nm, "_op"}, 64'(ext_op_E), 64'(ex_op));
    chk({nm, "_used"}, 64'(imm_used_E), 64'(ex_used));
  endtask

  logic [6:0] ops [10] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                           7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1110011};

  initial begin
    rst = 1'b1; in_valid = 1'b0; instrD = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; on = 1;

    send(32'hFFF00093, 32'hFFFFFFFF, 6'b010000, 1'b1, "addi");
    send(32'h00509093, 32'h00000005, 6'b100000, 1'b1, "slli");
    send(32'h40505093, 32'h00000005, 6'b100000, 1'b1, "srai");
    send(32'hFE000EE3, 32'hFFFFFFFC, 6'b000100, 1'b1, "beq");
    send(32'h123450B7, 32'h12345000, 6'b000010, 1'b1, "lui");
    send(32'h00000033, 32'h00000000, 6'b000000, 1'b0, "add");
    tick();

    // backpressure: two accepts, then in_ready drops; release drains in order
    out_ready = 1'b0; in_valid = 1'b1; instrD = 32'h00100093;
    tick(); instrD = 32'h00200093;
    tick(); instrD = 32'h00300093;
    tick();
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_imm", 64'(imm_E), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_second_imm", 64'(imm_E), 64'd2);
    tick();
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // flush while full with a competing input
    out_ready = 1'b0; in_valid = 1'b1; instrD = 32'h00400093;
    tick(); instrD = 32'h00500093;
    tick(); flush = 1'b1; instrD = 32'h00600093;
    tick(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();

    // reset while holding one entry
    out_ready = 1'b0; in_valid = 1'b1; instrD = 32'hFFF00093;
    tick(); in_valid = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(imm_E), 64'd0);
    chk("rst_op", 64'(ext_op_E), 64'd0);
`ifdef IMM_PERF_CNT_EN
    chk("rst_cnt_imm", 64'(cnt_imm), 64'd0);
    chk("rst_cnt_stl", 64'(cnt_stl), 64'd0);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      r      = $urandom();
      r[6:0] = ops[$urandom_range(0, 9)];
      instrD    = r;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
